// File: rtl/chan_mux_rr.sv
// Registered N-channel selector with per-channel valid/ready handshakes,
// direct (sel) or round-robin channel selection, and a one-word output register.
module chan_mux_rr #(
  parameter int NUM_CH = 31,
  parameter int DW     = 2,
  parameter int SELW   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NUM_CH*DW-1:0] in_data,
  input  logic [NUM_CH-1:0]    in_valid,
  output logic [NUM_CH-1:0]    in_ready,
  output logic [DW-1:0]        out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 err_sel
);

  localparam int              NP      = 2 ** SELW;
  localparam logic [SELW:0]   NCH_W   = (SELW + 1)'(NUM_CH);
  localparam logic [SELW-1:0] LAST_CH = SELW'(NUM_CH - 1);

  logic [DW-1:0]   out_data_q;
  logic [SELW-1:0] out_ch_q;
  logic            out_valid_q;
  logic            err_sel_q;
  logic [SELW-1:0] rr_ptr_q;

  logic            can_load;
  logic            sel_oor;
  logic            gnt_ok;
  logic [SELW-1:0] gnt_idx;
  logic [SELW:0]   cand;
  logic [NP-1:0]   valid_pad;
  logic [DW-1:0]   data_arr [NP];

  // Pad channel views to the full index space so any SELW-bit index is in range.
  assign valid_pad = NP'(in_valid);

  genvar k;
  generate
    for (k = 0; k < NP; k++) begin : g_pad
      if (k < NUM_CH) begin : g_ch
        assign data_arr[k] = in_data[k*DW +: DW];
      end else begin : g_nc
        assign data_arr[k] = '0;
      end
    end
  endgenerate

  assign can_load = !out_valid_q || out_ready;
  assign sel_oor  = ({1'b0, sel} >= NCH_W);

  always_comb begin
    gnt_ok  = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (!reset && can_load) begin
      if (!mode) begin
        gnt_ok  = !sel_oor && valid_pad[sel];
        gnt_idx = sel;
      end else begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          cand = {1'b0, rr_ptr_q} + (SELW + 1)'(i);
          if (cand >= NCH_W) cand = cand - NCH_W;
          if (!gnt_ok && valid_pad[cand[SELW-1:0]]) begin
            gnt_ok  = 1'b1;
            gnt_idx = cand[SELW-1:0];
          end
        end
      end
    end
  end

  assign in_ready = gnt_ok ? (NUM_CH'(1) << gnt_idx) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      err_sel_q   <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      err_sel_q <= !mode && can_load && sel_oor;
      if (gnt_ok) begin
        out_data_q  <= data_arr[gnt_idx];
        out_ch_q    <= gnt_idx;
        out_valid_q <= 1'b1;
        if (mode) rr_ptr_q <= (gnt_idx == LAST_CH) ? '0 : gnt_idx + SELW'(1);
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
  assign err_sel   = err_sel_q;

endmodule
